// File: rtl/multiword_add_seq.sv
// Multi-precision adder sequencer: one 32-bit word pair per cycle, LSW first, carry chained in a register.
// Optional macro MULTIWORD_SUB_EN adds in_sub to turn an operation into A - B.
module multiword_add_seq #(
    parameter int WORDS = 4,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
`ifdef MULTIWORD_SUB_EN
    input  logic        in_sub,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic        out_last,
    output logic        out_carryout,
    output logic        out_overflow
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             carry_reg;
    logic             xfer;
    logic             sub_now;
    logic             cin;
    logic [31:0]      b_eff;
    logic [32:0]      full;
    logic             c30;
    logic             is_last;

`ifdef MULTIWORD_SUB_EN
    logic sub_reg;
    // The operation mode is taken from the port only on the LSW, then held.
    assign sub_now = (state == IDLE) ? in_sub : sub_reg;
`else
    assign sub_now = 1'b0;
`endif

    assign in_ready = !out_valid || out_ready;
    assign xfer     = in_valid && in_ready;
    assign b_eff    = sub_now ? ~in_b : in_b;
    assign cin      = (state == IDLE) ? sub_now : carry_reg;
    assign full     = {1'b0, in_a} + {1'b0, b_eff} + {32'd0, cin};
    // Carry into bit 31 recovered from the sum bit and the operand bits.
    assign c30      = full[31] ^ in_a[31] ^ b_eff[31];
    assign is_last  = (state == IDLE) ? (WORDS == 1) : (cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            carry_reg    <= 1'b0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_last     <= 1'b0;
            out_carryout <= 1'b0;
            out_overflow <= 1'b0;
`ifdef MULTIWORD_SUB_EN
            sub_reg      <= 1'b0;
`endif
        end else if (xfer) begin
            out_valid    <= 1'b1;
            out_sum      <= full[31:0];
            out_last     <= is_last;
            out_carryout <= is_last & full[32];
            out_overflow <= is_last & (c30 ^ full[32]);
`ifdef MULTIWORD_SUB_EN
            sub_reg      <= sub_now;
`endif
            if (is_last) begin
                state     <= IDLE;
                cnt       <= '0;
                carry_reg <= 1'b0;
            end else begin
                state     <= RUN;
                cnt       <= cnt + 1'b1;
                carry_reg <= full[32];
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
